// File: rtl/lbp_window_gen.sv
// Raster pixel stream to 3x3 neighbourhood windows, using two line buffers and a 3x3 register array.
// Optional frameEnd output is enabled by defining LBP_WINDOW_FRAME_END_EN.
module lbp_window_gen #(
    parameter int inputWidth  = 8,
    parameter int imageWidth  = 640,
    parameter int imageHeight = 480
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [inputWidth-1:0]   pixelIn,
    input  logic                    pixelValid,
    input  logic                    frameStart,
    output logic [inputWidth*9-1:0] windowOut,
    output logic                    windowValid
`ifdef LBP_WINDOW_FRAME_END_EN
    ,
    output logic                    frameEnd
`endif
);

    localparam int COL_W = $clog2(imageWidth);
    localparam int ROW_W = $clog2(imageHeight);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(imageWidth - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(imageHeight - 1);

    logic [COL_W-1:0]      col_q, col_d, cur_col;
    logic [ROW_W-1:0]      row_q, row_d, cur_row;
    logic [inputWidth-1:0] lb1_mem [imageWidth];
    logic [inputWidth-1:0] lb2_mem [imageWidth];
    logic [inputWidth-1:0] lb1_rd, lb2_rd;
    logic [inputWidth-1:0] win_q [9];
    logic [inputWidth-1:0] win_d [9];
    logic                  win_valid_q, win_valid_d;
    logic                  in_window;

    // frameStart re-anchors the accepted pixel to (0,0) whatever the counters say.
    assign cur_col   = frameStart ? '0 : col_q;
    assign cur_row   = frameStart ? '0 : row_q;
    assign in_window = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

    assign lb1_rd = lb1_mem[cur_col];
    assign lb2_rd = lb2_mem[cur_col];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        if (pixelValid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]     = win_q[r*3 + 1];
                win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2]    = lb2_rd;
            win_d[5]    = lb1_rd;
            win_d[8]    = pixelIn;
            win_valid_d = in_window;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
        end
    end

    // NOTE: line buffer RAMs are deliberately not reset; stale rows are masked by the row>=2 gate.
    always_ff @(posedge clk) begin
        if (pixelValid) begin
            lb1_mem[cur_col] <= pixelIn;
            lb2_mem[cur_col] <= lb1_rd;
        end
    end

    for (genvar i = 0; i < 9; i++) begin : g_pack
        assign windowOut[i*inputWidth +: inputWidth] = win_q[i];
    end

    assign windowValid = win_valid_q;

`ifdef LBP_WINDOW_FRAME_END_EN
    logic frame_end_q;

    // Only the true last pixel reaches (last row, last col); aborts re-anchor the counters first.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= pixelValid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
    end

    assign frameEnd = frame_end_q;
`endif

endmodule
